uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin arbiter that shares the single `uart_basic` transmitter (115200 8N1, 100 MHz) among `N_REQ` byte producers. Each requester offers bytes over a valid/ready handshake and marks packet ends with `last`. The arbiter sequences `tx_start`/`tx_data` against `tx_busy` and enforces an inter-byte gap. It holds the grant for a whole packet, so multi-byte records (e.g. 16-bit results sent as 2 bytes) are never interleaved. It sits between the system's data sources and `uart_basic`, replacing the single-source TX control path.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `INTER_BYTE_DELAY`, 100_000: idle clock cycles inserted after `tx_busy` falls, before the next `tx_start`. A value of 0 means no gap.
- `BUSY_WAIT_MAX`, 4: cycles after `tx_start` to wait for `tx_busy` to rise before treating the byte as sent.
- `clk_100M` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `req_valid` in N_REQ: requester i offers a byte.
- `req_data` in N_REQ×8 (packed `[N_REQ-1:0][7:0]`): byte offered by requester i.
- `req_last` in N_REQ: the offered byte is the final byte of its packet.
- `req_ready` out N_REQ: byte accepted this cycle; at most one bit set.
- `tx_start` out 1: one-cycle start pulse to `uart_basic`.
- `tx_data` out 8: byte to `uart_basic`; stable from the `tx_start` cycle until the next accept.
- `tx_busy` in 1: transmitter busy flag from `uart_basic`.
- `grant_id` out $clog2(N_REQ): current or last owner.
- `grant_active` out 1: a packet is in progress (the grant is locked).

## Operation
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, GAP.
- IDLE:
  - If `tx_busy`=1, wait.
  - Else, if locked, only `grant_id` is eligible. If unlocked, search from `rr_ptr` upward with wrap for the first `req_valid`.
  - On a hit: `req_ready[sel]`=1 (combinational, same cycle), register `tx_data<=req_data[sel]`, `grant_id<=sel`, `last_q<=req_last[sel]`, `grant_active<=1`. Go to ISSUE.
- ISSUE: `tx_start`=1 for exactly this cycle. Go to WAIT_BUSY.
- WAIT_BUSY:
  - `tx_busy`=1 → WAIT_DONE.
  - Counter reaches `BUSY_WAIT_MAX` → GAP (byte considered lost-but-sent; no retry).
- WAIT_DONE: stay while `tx_busy`=1. Fall → GAP.
- GAP:
  - Count `INTER_BYTE_DELAY` cycles (skipped if 0), then go to IDLE.
  - On exit, if `last_q`=1: `grant_active<=0`, `rr_ptr<=(grant_id+1) mod N_REQ`.
  - Otherwise the lock stays and the owner is the only eligible requester.
- A locked owner that stops asserting valid stalls the arbiter indefinitely (by design; producers must complete packets).
- Only one outstanding byte exists at any time; `req_ready` is never asserted outside IDLE.

## Timing
- Reset values: `tx_start`=0, `tx_data`=0, `req_ready`=0, `grant_id`=0, `grant_active`=0, `rr_ptr`=0, state IDLE, counters 0.
- Latency: `req_valid` sampled in cycle t (arbiter IDLE, `tx_busy`=0) → `req_ready` in t → `tx_start` in t+1.
- Byte-to-byte spacing: `tx_busy` fall cycle f → GAP spans f+1..f+`INTER_BYTE_DELAY` → next `req_ready` no earlier than f+`INTER_BYTE_DELAY`+1.
- Simultaneous requests: the lowest index at or above `rr_ptr` (with wrap) wins.
- A `req_valid` drop before its handshake is allowed; no byte is taken.
- `reset_n` low mid-transfer:
  - All state clears immediately; `tx_start` never glitches high.
  - After release, IDLE waits for the `uart_basic` `tx_busy` to drop before issuing.
- The counter must hold `max(INTER_BYTE_DELAY, BUSY_WAIT_MAX)`; width is `$clog2` of that value + 1.

## Structure
- Package `uart_arb_pkg`: state enum typedef (`arb_state_t`), plus a `GRANT_W` helper function for the `grant_id` width.
- Sub-module `uart_rr_pick`: combinational rotating priority encoder.
  - Inputs: `req`, `ptr`, `lock`, `owner`.
  - Outputs: `hit`, `sel`.
- The FSM, counter and registers live in `uart_tx_arbiter`.

## Test plan
- Single requester, `INTER_BYTE_DELAY`=10: req0 sends 0xA5 (last) → one `tx_start`, `tx_data`=0xA5, `grant_active` falls after the gap, `rr_ptr`=1.
- All 4 valid with single-byte packets 0x10..0x13 (last=1) → TX order 0x10, 0x11, 0x12, 0x13; at least 10 idle cycles between each `tx_busy` fall and the next `tx_start`.
- Packet lock: req1 sends 0x34, 0x12 (last on 0x12) while req2 is valid → bytes 0x34, 0x12 go out back-to-back before req2's byte; `grant_id` stays 1.
- `tx_busy` tied low → each byte completes after `BUSY_WAIT_MAX` cycles plus the gap; no hang.
- Assert `reset_n` low during WAIT_DONE with `tx_busy` still high → outputs go to reset values at once. After release, no `tx_start` until `tx_busy`=0.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared FSM state type and grant-width helper for the UART TX arbiter
package uart_arb_pkg;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, GAP} arb_state_t;
  function automatic int GRANT_W(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/uart_rr_pick.sv
// uart_rr_pick: rotating priority encoder; when locked only the owner is eligible
module uart_rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  input  logic         lock,
  input  logic [W-1:0] owner,
  output logic         hit,
  output logic [W-1:0] sel
);
  always_comb begin
    hit = 1'b0;
    sel = ptr;
    if (lock) begin
      hit = req[owner];
      sel = owner;
    end else begin
      // scan from the far end so the nearest requester at or above ptr wins last
      for (int k = N - 1; k >= 0; k--) begin
        if (req[(int'(ptr) + k) % N]) begin
          hit = 1'b1;
          sel = W'((int'(ptr) + k) % N);
        end
      end
    end
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-locked round-robin sharing of one UART transmitter
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_REQ            = 4,
  parameter int INTER_BYTE_DELAY = 100_000,
  parameter int BUSY_WAIT_MAX    = 4
) (
  input  logic                         clk_100M,
  input  logic                         reset_n,
  input  logic [N_REQ-1:0]             req_valid,
  input  logic [N_REQ-1:0][7:0]        req_data,
  input  logic [N_REQ-1:0]             req_last,
  output logic [N_REQ-1:0]             req_ready,
  output logic                         tx_start,
  output logic [7:0]                   tx_data,
  input  logic                         tx_busy,
  output logic [GRANT_W(N_REQ)-1:0]    grant_id,
  output logic                         grant_active
);
  localparam int GW   = GRANT_W(N_REQ);
  localparam int CMAX = (INTER_BYTE_DELAY > BUSY_WAIT_MAX) ? INTER_BYTE_DELAY : BUSY_WAIT_MAX;
  localparam int CW   = $clog2(CMAX) + 1;
  arb_state_t     state;
  logic [CW-1:0]  cnt;
  logic [GW-1:0]  rr_ptr;
  logic [GW-1:0]  sel;
  logic           hit;
  logic           last_q;
  logic           take;
  uart_rr_pick #(.N(N_REQ), .W(GW)) u_pick (
    .req  (req_valid),
    .ptr  (rr_ptr),
    .lock (grant_active),
    .owner(grant_id),
    .hit  (hit),
    .sel  (sel)
  );
  assign take = (state == IDLE) && !tx_busy && hit;
  always_comb begin
    req_ready      = '0;
    req_ready[sel] = take;
  end
  always_ff @(posedge clk_100M or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      tx_start     <= 1'b0;
      tx_data      <= '0;
      grant_id     <= '0;
      grant_active <= 1'b0;
      rr_ptr       <= '0;
      last_q       <= 1'b0;
      cnt          <= '0;
    end else begin
      case (state)
        IDLE: if (take) begin
          tx_data      <= req_data[sel];
          grant_id     <= sel;
          last_q       <= req_last[sel];
          grant_active <= 1'b1;
          tx_start     <= 1'b1;
          state        <= ISSUE;
        end
        ISSUE: begin
          tx_start <= 1'b0;
          cnt      <= '0;
          state    <= WAIT_BUSY;
        end
        // a transmitter that never raises busy is treated as having sent the byte
        WAIT_BUSY: if (tx_busy) state <= WAIT_DONE;
          else if (int'(cnt) + 1 >= BUSY_WAIT_MAX) begin
            cnt   <= '0;
            state <= GAP;
          end else cnt <= cnt + 1'b1;
        WAIT_DONE: if (!tx_busy) begin
          cnt   <= '0;
          state <= GAP;
        end
        GAP: if (int'(cnt) + 1 >= INTER_BYTE_DELAY) begin
          state <= IDLE;
          if (last_q) begin
            grant_active <= 1'b0;
            rr_ptr       <= (int'(grant_id) == N_REQ - 1) ? '0 : grant_id + 1'b1;
          end
        end else cnt <= cnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed scoreboard bench with a simple uart_basic busy model
module tb_uart_tx_arbiter;
  import uart_arb_pkg::*;
  localparam int N = 4, IBD = 10, BWM = 4, BUSY_LEN = 20;
  logic clk = 1'b0, reset_n = 1'b0, tx_busy = 1'b0;
  logic tx_start, grant_active;
  logic [N-1:0] req_valid = '0, req_last = '0, req_ready;
  logic [N-1:0][7:0] req_data = '0;
  logic [7:0] tx_data;
  logic [1:0] grant_id;
  int chk = 0, errs = 0, cyc = 0, nstart = 0, fall_cyc = -1, bcnt = 0, s0 = 0, n = 0;
  logic hold_busy = 1'b0, busy_low = 1'b0, prev_busy = 1'b0, prev_start = 1'b0;
  logic [8:0] pq[N][$];
  logic [N-1:0] taken = '0;
  logic [9:0] exp_q[$];
  int starts[$];

  uart_tx_arbiter #(.N_REQ(N), .INTER_BYTE_DELAY(IBD), .BUSY_WAIT_MAX(BWM)) dut (
    .clk_100M(clk), .reset_n(reset_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .tx_start(tx_start), .tx_data(tx_data),
    .tx_busy(tx_busy), .grant_id(grant_id), .grant_active(grant_active)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit pending();
    bit p = exp_q.size() > 0;
    for (int i = 0; i < N; i++) p |= pq[i].size() > 0;
    return p;
  endfunction

  // busy rises in the start cycle and stays high BUSY_LEN cycles
  initial forever begin
    @(posedge clk); #1;
    if (tx_start && !busy_low) bcnt = BUSY_LEN;
    else if (bcnt > 0) bcnt--;
    tx_busy = hold_busy || bcnt > 0;
  end

  initial forever begin
    @(posedge clk); #2;
    for (int i = 0; i < N; i++) begin
      if (taken[i]) begin
        void'(pq[i].pop_front());
        taken[i] = 1'b0;
      end
      req_valid[i] = pq[i].size() > 0;
      req_data[i]  = (pq[i].size() > 0) ? pq[i][0][7:0] : 8'h00;
      req_last[i]  = (pq[i].size() > 0) ? pq[i][0][8] : 1'b0;
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      check("ready_onehot0", 32'($onehot0(req_ready)), 1);
      for (int i = 0; i < N; i++) if (req_valid[i] && req_ready[i]) taken[i] = 1'b1;
      if (prev_busy && !tx_busy && grant_active) fall_cyc = cyc;
      if (tx_start) begin
        check("start_one_cycle", 32'(prev_start), 0);
        nstart++;
        starts.push_back(cyc);
        if (fall_cyc >= 0) begin
          check("inter_byte_gap", 32'(cyc - fall_cyc >= IBD + 2), 1);
          fall_cyc = -1;
        end
        if (exp_q.size() == 0) check("sb_has_entry", 32'(exp_q.size()), 1);
        else begin
          logic [9:0] e;
          e = exp_q.pop_front();
          check("tx_data", 32'(tx_data), 32'(e[7:0]));
          check("grant_id", 32'(grant_id), 32'(e[9:8]));
          check("grant_active_on_start", 32'(grant_active), 1);
        end
      end
    end
    prev_busy  = tx_busy;
    prev_start = tx_start;
  end

  task automatic wait_done(input int maxc);
    n = 0;
    while ((pending() || grant_active) && n < maxc) begin
      @(posedge clk); #1;
      n++;
    end
    check("wait_done_in_budget", 32'(n < maxc), 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tx_start"}, 32'(tx_start), 0);
    check({tag, "_tx_data"}, 32'(tx_data), 0);
    check({tag, "_req_ready"}, 32'(req_ready), 0);
    check({tag, "_grant_id"}, 32'(grant_id), 0);
    check({tag, "_grant_active"}, 32'(grant_active), 0);
    check({tag, "_rr_ptr"}, 32'(dut.rr_ptr), 0);
  endtask

  initial begin
    repeat (3) @(posedge clk); #1;
    check_reset_outputs("rst");
    reset_n = 1'b1;
    // single requester, single-byte packet
    exp_q.push_back({2'd0, 8'hA5});
    pq[0].push_back({1'b1, 8'hA5});
    wait_done(200);
    check("t1_starts", 32'(nstart), 1);
    check("t1_rr_ptr", 32'(dut.rr_ptr), 1);
    check("t1_grant_active", 32'(grant_active), 0);
    // fresh reset so the round robin starts at requester 0
    reset_n = 1'b0; #1;
    check_reset_outputs("rst2");
    @(posedge clk); #1;
    reset_n = 1'b1;
    fall_cyc = -1;
    s0 = nstart;
    for (int i = 0; i < N; i++) begin
      exp_q.push_back({2'(i), 8'h10 + 8'(i)});
      pq[i].push_back({1'b1, 8'h10 + 8'(i)});
    end
    wait_done(600);
    check("t2_starts", 32'(nstart - s0), 4);
    check("t2_rr_ptr", 32'(dut.rr_ptr), 0);
    // two-byte packet from req1 must not be split by req2
    s0 = nstart;
    pq[1].push_back({1'b0, 8'h34});
    pq[1].push_back({1'b1, 8'h12});
    pq[2].push_back({1'b1, 8'h56});
    exp_q.push_back({2'd1, 8'h34});
    exp_q.push_back({2'd1, 8'h12});
    exp_q.push_back({2'd2, 8'h56});
    wait_done(600);
    check("t3_starts", 32'(nstart - s0), 3);
    check("t3_grant_id", 32'(grant_id), 2);
    check("t3_rr_ptr", 32'(dut.rr_ptr), 3);
    // transmitter never raises busy
    busy_low = 1'b1;
    s0 = starts.size();
    pq[0].push_back({1'b0, 8'h9C});
    pq[0].push_back({1'b1, 8'h9D});
    exp_q.push_back({2'd0, 8'h9C});
    exp_q.push_back({2'd0, 8'h9D});
    wait_done(200);
    check("t4_starts", 32'(starts.size() - s0), 2);
    if (starts.size() >= s0 + 2) check("t4_spacing", 32'(starts[s0+1] - starts[s0]), 1 + BWM + IBD + 1);
    busy_low = 1'b0;
    // reset while the transmitter is still busy
    s0 = nstart;
    pq[2].push_back({1'b1, 8'hE1});
    exp_q.push_back({2'd2, 8'hE1});
    n = 0;
    while (nstart == s0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("t5_first_start", 32'(nstart - s0), 1);
    repeat (5) @(posedge clk); #2;
    check("t5_in_wait_done", 32'(dut.state), 32'(WAIT_DONE));
    hold_busy = 1'b1;
    reset_n = 1'b0; #1;
    check("t5_rst_tx_start", 32'(tx_start), 0);
    check("t5_rst_tx_data", 32'(tx_data), 0);
    check("t5_rst_grant_active", 32'(grant_active), 0);
    check("t5_rst_grant_id", 32'(grant_id), 0);
    check("t5_rst_state", 32'(dut.state), 32'(IDLE));
    @(posedge clk); #2;
    reset_n = 1'b1;
    s0 = nstart;
    pq[0].push_back({1'b1, 8'h3C});
    exp_q.push_back({2'd0, 8'h3C});
    repeat (30) @(posedge clk);
    #1;
    check("t5_no_start_while_busy", 32'(nstart - s0), 0);
    check("t5_ready_held_off", 32'(req_ready), 0);
    hold_busy = 1'b0;
    wait_done(200);
    check("t5_start_after_busy", 32'(nstart - s0), 1);
    check("t5_sb_drained", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", chk, errs);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
